// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide, combinational-read data memory.
// Sub-word stores use read-modify-write; loads are lane-selected and extended.
module mem_access_unit #(
   parameter int RAM_SIZE_BIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] Address,
   output logic [31:0] Write_data,
   output logic        MemRead,
   output logic        MemWrite,
   input  logic [31:0] Read_data
);

   typedef enum logic [1:0] {IDLE, LD, RMW_RD, WR} state_t;

   state_t      state_reg, state_next;
   logic [31:0] addr_reg;
   logic [1:0]  size_reg;
   logic        sign_reg;
   logic [15:0] wdata_reg;
   logic [31:0] wbuf_reg;
   logic [31:0] rdata_reg;
   logic        done_reg;
   logic        err_reg;

   logic        bad;
   logic        accept;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_value;
   logic [31:0] merged;

   always_comb begin
      bad = 1'b0;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = addr[0];
         2'b10:   bad = |addr[1:0];
         default: bad = 1'b1;
      endcase
      if ((addr >> (RAM_SIZE_BIT + 2)) != 32'd0)
         bad = 1'b1;
   end

   assign accept = (state_reg == IDLE) && req && !bad;

   // Lane extraction for loads and lane replacement for sub-word stores.
   always_comb begin
      ld_byte = Read_data[{addr_reg[1:0], 3'b000} +: 8];
      ld_half = Read_data[{addr_reg[1], 4'b0000} +: 16];
      case (size_reg)
         2'b00:   load_value = sign_reg ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
         2'b01:   load_value = sign_reg ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
         default: load_value = Read_data;
      endcase
      merged = Read_data;
      if (size_reg == 2'b00)
         merged[{addr_reg[1:0], 3'b000} +: 8] = wdata_reg[7:0];
      else
         merged[{addr_reg[1], 4'b0000} +: 16] = wdata_reg;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         addr_reg  <= 32'd0;
         size_reg  <= 2'b00;
         sign_reg  <= 1'b0;
         wdata_reg <= 16'd0;
         wbuf_reg  <= 32'd0;
         rdata_reg <= 32'd0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= (state_reg == LD) || (state_reg == WR);
         err_reg   <= (state_reg == IDLE) && req && bad;
         if (accept) begin
            addr_reg  <= addr;
            size_reg  <= size;
            sign_reg  <= sign_ext;
            wdata_reg <= wdata[15:0];
            wbuf_reg  <= wdata;
         end
         if (state_reg == LD)
            rdata_reg <= load_value;
         if (state_reg == RMW_RD)
            wbuf_reg <= merged;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (!we)
                  state_next = LD;
               else if (size == 2'b10)
                  state_next = WR;
               else
                  state_next = RMW_RD;
            end
         end
         LD:      state_next = IDLE;
         RMW_RD:  state_next = WR;
         WR:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory port is decoded purely from registered state and latched request.
   always_comb begin
      ready      = (state_reg == IDLE);
      MemRead    = (state_reg == LD) || (state_reg == RMW_RD);
      MemWrite   = (state_reg == WR);
      Address    = (state_reg == IDLE) ? 32'd0 : {addr_reg[31:2], 2'b00};
      Write_data = (state_reg == WR) ? wbuf_reg : 32'd0;
      done       = done_reg;
      err        = err_reg;
      rdata      = rdata_reg;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a bench-owned memory serves the port,
// a shadow copy predicts load results and completion/reject pulses.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset, req, we, sign_ext;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        ready, done, err, MemRead, MemWrite;
   logic [31:0] rdata, Address, Write_data, Read_data;

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic        clear_mem;

   typedef struct {
      bit          is_err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          fails = 0;
   int          mw_cycles = 0;
   logic [31:0] last_rdata = 32'd0;

   always #5 clk = ~clk;

   mem_access_unit #(.RAM_SIZE_BIT(8)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready),
      .done(done), .err(err), .rdata(rdata), .Address(Address),
      .Write_data(Write_data), .MemRead(MemRead), .MemWrite(MemWrite),
      .Read_data(Read_data)
   );

   assign Read_data = mem[Address[9:2]];

   always @(posedge clk) begin
      if (clear_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      end else if (MemWrite) begin
         mem[Address[9:2]] <= Write_data;
      end
   end

   // Scoreboard consumer: every done/err pulse pops one expected completion.
   always @(negedge clk) begin
      exp_t e;
      if (MemWrite) mw_cycles++;
      if (MemRead && MemWrite) begin
         fails++;
         $display("FAIL port_exclusive: MemRead=%b MemWrite=%b required not both 1", MemRead, MemWrite);
      end
      if (done && err) begin
         fails++;
         $display("FAIL done_err_exclusive: done=%b err=%b required not both 1", done, err);
      end
      if (done || err) begin
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_completion: done=%b err=%b with no outstanding request", done, err);
         end else begin
            e = sb.pop_front();
            checks++;
            if (err !== e.is_err) begin
               fails++;
               $display("FAIL sb_kind: err=%b done=%b required err=%b", err, done, e.is_err);
            end
            checks++;
            if (rdata !== e.rdata) begin
               fails++;
               $display("FAIL sb_rdata: got %h required %h", rdata, e.rdata);
            end
         end
      end
   end

   function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] sz, bit sx);
      logic [31:0] w;
      logic [31:0] r;
      w = ref_mem[a[9:2]];
      case (sz)
         2'd0: begin
            r = (w >> (8 * a[1:0])) & 32'h0000_00FF;
            if (sx && r[7]) r = r | 32'hFFFF_FF00;
         end
         2'd1: begin
            r = (w >> (16 * a[1])) & 32'h0000_FFFF;
            if (sx && r[15]) r = r | 32'hFFFF_0000;
         end
         default: r = w;
      endcase
      return r;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] w;
      int sh;
      w = ref_mem[a[9:2]];
      case (sz)
         2'd0: begin sh = 8 * a[1:0];  w = (w & ~(32'h0000_00FF << sh)) | ((d & 32'h0000_00FF) << sh); end
         2'd1: begin sh = 16 * a[1];   w = (w & ~(32'h0000_FFFF << sh)) | ((d & 32'h0000_FFFF) << sh); end
         default: w = d;
      endcase
      ref_mem[a[9:2]] = w;
   endtask

   // Called just after a falling edge; holds req for 'hold' rising edges.
   task automatic drive(input bit w, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                        input logic [31:0] d, input bit track, input int hold);
      bit   bad;
      exp_t e;
      bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (a[31:10] != 22'd0);
      if (track) begin
         if (bad) begin
            e.is_err = 1'b1;
         end else if (!w) begin
            last_rdata = model_load(a, sz, sx);
            e.is_err = 1'b0;
         end else begin
            model_store(a, sz, d);
            e.is_err = 1'b0;
         end
         e.rdata = last_rdata;
         sb.push_back(e);
      end
      we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
      repeat (hold) @(posedge clk);
      #1 req = 1'b0;
   endtask

   task automatic test_reset();
      req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'd0; wdata = 32'd0;
      clear_mem = 1'b1;
      reset = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
      repeat (3) @(negedge clk);
      checks++; if (ready !== 1'b1)      begin fails++; $display("FAIL reset_ready: got %b required 1", ready); end
      checks++; if (done !== 1'b0)       begin fails++; $display("FAIL reset_done: got %b required 0", done); end
      checks++; if (err !== 1'b0)        begin fails++; $display("FAIL reset_err: got %b required 0", err); end
      checks++; if (rdata !== 32'd0)     begin fails++; $display("FAIL reset_rdata: got %h required 0", rdata); end
      checks++; if (Address !== 32'd0)   begin fails++; $display("FAIL reset_address: got %h required 0", Address); end
      checks++; if (Write_data !== 32'd0) begin fails++; $display("FAIL reset_wdata: got %h required 0", Write_data); end
      checks++; if (MemRead !== 1'b0 || MemWrite !== 1'b0)
         begin fails++; $display("FAIL reset_mem_en: MemRead=%b MemWrite=%b required 0 0", MemRead, MemWrite); end
      clear_mem = 1'b0;
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word();
      drive(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1);
      @(negedge clk);
      checks++; if (MemWrite !== 1'b1 || MemRead !== 1'b0)
         begin fails++; $display("FAIL word_store_en: MemWrite=%b MemRead=%b required 1 0", MemWrite, MemRead); end
      checks++; if (Address !== 32'h10) begin fails++; $display("FAIL word_store_addr: got %h required 00000010", Address); end
      checks++; if (Write_data !== 32'hDEADBEEF) begin fails++; $display("FAIL word_store_data: got %h required deadbeef", Write_data); end
      checks++; if (ready !== 1'b0) begin fails++; $display("FAIL word_store_busy: ready=%b required 0", ready); end
      @(negedge clk);
      checks++; if (MemWrite !== 1'b0) begin fails++; $display("FAIL word_store_once: MemWrite=%b required 0", MemWrite); end
      drive(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 1);
      repeat (2) @(negedge clk);
      checks++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL word_load: got %h required deadbeef", rdata); end
      $display("word store/load at 0x10 complete, rdata=%h", rdata);
   endtask

   task automatic test_loads();
      logic [31:0] a_t [5] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10};
      logic [1:0]  s_t [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
      bit          x_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] r_t [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD, 32'hFFFFFFEF};
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, s_t[i], x_t[i], a_t[i], 32'd0, 1'b1, 1);
         repeat (2) @(negedge clk);
         checks++;
         if (rdata !== r_t[i]) begin fails++; $display("FAIL subword_load_%0d: got %h required %h", i, rdata, r_t[i]); end
         $display("load addr=%h size=%0d sx=%0d rdata=%h", a_t[i], s_t[i], x_t[i], rdata);
      end
   endtask

   task automatic test_subword_store();
      drive(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055, 1'b1, 1);
      @(negedge clk);
      checks++; if (MemRead !== 1'b1 || MemWrite !== 1'b0 || Address !== 32'h10)
         begin fails++; $display("FAIL rmw_read: MemRead=%b MemWrite=%b Address=%h required 1 0 00000010", MemRead, MemWrite, Address); end
      @(negedge clk);
      checks++; if (MemWrite !== 1'b1 || Write_data !== 32'hDEAD55EF)
         begin fails++; $display("FAIL byte_store_write: MemWrite=%b data=%h required 1 dead55ef", MemWrite, Write_data); end
      @(negedge clk);
      drive(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 1'b1, 1);
      repeat (2) @(negedge clk);
      checks++; if (Write_data !== 32'h123455EF)
         begin fails++; $display("FAIL half_store_write: got %h required 123455ef", Write_data); end
      @(negedge clk);
      drive(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 1);
      repeat (2) @(negedge clk);
      checks++; if (rdata !== 32'h123455EF) begin fails++; $display("FAIL rmw_final: got %h required 123455ef", rdata); end
      $display("sub-word stores at 0x11/0x12 complete, word=%h", rdata);
   endtask

   task automatic test_reject();
      logic [31:0] a_t [4] = '{32'h11, 32'h12, 32'h0, 32'h400};
      logic [1:0]  s_t [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
      int mw0;
      mw0 = mw_cycles;
      for (int i = 0; i < 4; i++) begin
         drive(i[0], s_t[i], 1'b0, a_t[i], 32'hFFFFFFFF, 1'b1, 1);
         @(negedge clk);
         checks++;
         if (ready !== 1'b1 || MemRead !== 1'b0 || MemWrite !== 1'b0 || err !== 1'b1)
            begin fails++; $display("FAIL reject_%0d: ready=%b rd=%b wr=%b err=%b required 1 0 0 1", i, ready, MemRead, MemWrite, err); end
         $display("reject addr=%h size=%0d err=%b", a_t[i], s_t[i], err);
      end
      @(negedge clk);
      checks++; if (mw_cycles != mw0) begin fails++; $display("FAIL reject_no_write: %0d write cycles required 0", mw_cycles - mw0); end
      checks++; if (mem[4] !== 32'h123455EF || mem[0] !== 32'd0)
         begin fails++; $display("FAIL reject_mem: mem[4]=%h mem[0]=%h required 123455ef 0", mem[4], mem[0]); end
   endtask

   task automatic test_busy_hold();
      int mw0;
      mw0 = mw_cycles;
      drive(1'b1, 2'd0, 1'b0, 32'h21, 32'h00000077, 1'b1, 3);
      repeat (2) @(negedge clk);
      checks++; if (mw_cycles - mw0 != 1) begin fails++; $display("FAIL busy_store_writes: %0d write cycles required 1", mw_cycles - mw0); end
      drive(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b1, 2);
      repeat (2) @(negedge clk);
      checks++; if (rdata !== 32'h00007700) begin fails++; $display("FAIL busy_load: got %h required 00007700", rdata); end
      $display("held-req store+load at 0x20 rdata=%h", rdata);
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 1'b1, 1);
      @(negedge clk);
      @(negedge clk);
      checks++; if (ready !== 1'b1 || done !== 1'b1)
         begin fails++; $display("FAIL b2b_done_ready: ready=%b done=%b required 1 1", ready, done); end
      drive(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b1, 1);
      @(negedge clk);
      checks++; if (MemRead !== 1'b1 || Address !== 32'h40)
         begin fails++; $display("FAIL b2b_load_issue: MemRead=%b Address=%h required 1 00000040", MemRead, Address); end
      @(negedge clk);
      checks++; if (rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL b2b_load: got %h required cafef00d", rdata); end
      drive(1'b0, 2'd1, 1'b0, 32'h41, 32'd0, 1'b1, 1);
      @(negedge clk);
      checks++; if (err !== 1'b1) begin fails++; $display("FAIL b2b_reject: err=%b required 1", err); end
      @(negedge clk);
      $display("back-to-back store/load/reject at 0x40 rdata=%h", rdata);
   endtask

   task automatic test_reset_abort();
      drive(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 1'b0, 1);
      @(negedge clk);
      checks++; if (MemRead !== 1'b1) begin fails++; $display("FAIL abort_in_rmw: MemRead=%b required 1", MemRead); end
      #2 reset = 1'b0;
      #1;
      last_rdata = 32'd0;
      checks++; if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || rdata !== 32'd0)
         begin fails++; $display("FAIL abort_status: ready=%b done=%b err=%b rdata=%h required 1 0 0 0", ready, done, err, rdata); end
      checks++; if (Address !== 32'd0 || Write_data !== 32'd0 || MemRead !== 1'b0 || MemWrite !== 1'b0)
         begin fails++; $display("FAIL abort_port: Address=%h data=%h rd=%b wr=%b required 0 0 0 0", Address, Write_data, MemRead, MemWrite); end
      repeat (2) begin
         @(negedge clk);
         checks++; if (MemWrite !== 1'b0) begin fails++; $display("FAIL abort_no_write: MemWrite=%b required 0", MemWrite); end
      end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (mem[4] !== ref_mem[4]) begin fails++; $display("FAIL abort_mem: got %h required %h", mem[4], ref_mem[4]); end
      drive(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 1);
      repeat (2) @(negedge clk);
      $display("reset abort during RMW: word 0x10=%h", rdata);
   endtask

   initial begin
      test_reset();
      test_word();
      test_loads();
      test_subword_store();
      test_reject();
      test_busy_hold();
      test_back_to_back();
      test_reset_abort();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin fails++; $display("FAIL sb_drain: %0d completions outstanding required 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the CPU datapath and the word-wide data memory. Accepts byte, halfword and word load/store requests from the CPU, checks alignment and range, and drives the memory's Address/Write_data/MemRead/MemWrite port. Sub-word stores are done as read-modify-write over the 32-bit memory port; loads are sign- or zero-extended. The memory reads combinationally and writes on the rising clock edge; this block is the only master of that port.

## Interface
- RAM_SIZE_BIT, 8, log2 of memory depth in words; byte address space is 2^(RAM_SIZE_BIT+2).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only when ready=1.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- ready  out  1  1 when idle and able to accept req.
- done  out  1  one-cycle pulse: accepted access completed.
- err  out  1  one-cycle pulse: request rejected.
- rdata  out  32  load result; holds until next load completes.
- Address  out  32  memory word address, {addr_q[31:2],2'b00}; 0 when idle.
- Write_data  out  32  memory write word; 0 unless MemWrite=1.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- Read_data  in  32  memory read word (combinational from Address).

## Operation
- Little-endian lanes: byte k at addr[1:0]=k occupies bits [8k+7:8k]; half at addr[1]=h occupies [16h+15:16h].
- States: IDLE, LD, RMW_RD, WR.
- IDLE: ready=1. On req=1:
  - Reject (err=1 next cycle, stay IDLE, no memory access) if size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:RAM_SIZE_BIT+2]!=0.
  - Otherwise latch addr, we, size, sign_ext, wdata. Load -> LD; word store -> WR with write buffer = wdata; byte/half store -> RMW_RD.
- LD: MemRead=1. At clock edge: select lane from Read_data, extend per sign_ext/size into rdata, done=1, -> IDLE.
- RMW_RD: MemRead=1. At clock edge: write buffer = Read_data with addressed lane replaced by wdata[7:0] or wdata[15:0]; -> WR.
- WR: MemWrite=1, Write_data = write buffer. At clock edge (memory commits): done=1, -> IDLE.
- MemRead and MemWrite never both 1. req while ready=0 is ignored (no queueing). Stores never modify rdata.
- done and err are registered, high exactly one cycle, mutually exclusive. Next request may be accepted in the cycle done/err is high (state already IDLE).

## Timing
- Reset (reset=0, any time): state IDLE, ready=1, done=0, err=0, rdata=0, Address=0, Write_data=0, MemRead=0, MemWrite=0, buffers cleared. Reset during RMW_RD or WR aborts with no write issued after reset assertion; release needs no further action.
- Accepting edge = E0. Load: LD in cycle after E0, done and rdata valid 2 cycles after E0 accept (edge E1 result, visible cycle after E1). Word store: WR for 1 cycle, done 1 cycle later. Sub-word store: RMW_RD 1 cycle, WR 1 cycle, done after WR edge.
- Throughput: load/word store 1 access per 2 cycles; sub-word store per 3 cycles; rejected request per 1 cycle.
- Memory-side outputs are decoded from registered state and latched request only; no combinational path from req/addr to memory port.

## Test plan
- After reset: word store addr=0x10 wdata=0xDEADBEEF -> MemWrite=1 one cycle with Address=0x10, Write_data=0xDEADBEEF; done pulse; word load 0x10 -> rdata=0xDEADBEEF.
- With word 0x10=0xDEADBEEF: byte load 0x13 sign_ext=1 -> rdata=0xFFFFFFDE; sign_ext=0 -> 0x000000DE; half load 0x10 sign_ext=1 -> 0xFFFFBEEF.
- Byte store 0x11 wdata=0x00000055 -> MemRead cycle then MemWrite with Write_data=0xDEAD55EF; half store 0x12 wdata=0x1234 -> final word 0x123455EF.
- Misaligned half 0x11, word 0x12, size=11, addr=0x400 (RAM_SIZE_BIT=8) -> err pulse, ready stays 1, MemRead/MemWrite never asserted, memory unchanged.
- req held high during busy -> only first request executes; back-to-back req accepted in done cycle executes immediately.
- Assert reset in RMW_RD of a byte store -> no MemWrite, all outputs at reset values, target word unchanged.
